// File: rtl/res_st_sched_if.sv
// Allocation, wakeup, issue and occupancy signals between rename, the
// reservation-station scheduler and the back end.
interface res_st_sched_if #(
    parameter int unsigned RES_ST_DEPTH = 16,
    parameter int unsigned TAG_WIDTH    = 6
);
    localparam int unsigned ADDR_W = $clog2(RES_ST_DEPTH);

    logic                 alloc_req;
    logic [TAG_WIDTH-1:0] alloc_rs1_tag;
    logic [TAG_WIDTH-1:0] alloc_rs2_tag;
    logic                 alloc_rs1_rdy;
    logic                 alloc_rs2_rdy;
    logic                 alloc_gnt;
    logic [ADDR_W-1:0]    alloc_addr;
    logic                 wb_valid;
    logic [TAG_WIDTH-1:0] wb_tag;
    logic                 schedule_en;
    logic                 iss0_valid;
    logic                 iss1_valid;
    logic [ADDR_W-1:0]    iss0_addr;
    logic [ADDR_W-1:0]    iss1_addr;
    logic                 flush;
    logic [ADDR_W:0]      count;
    logic                 full;

    modport master (
        output alloc_req, alloc_rs1_tag, alloc_rs2_tag, alloc_rs1_rdy, alloc_rs2_rdy,
        output wb_valid, wb_tag, schedule_en, flush,
        input  alloc_gnt, alloc_addr, iss0_valid, iss1_valid, iss0_addr, iss1_addr,
        input  count, full
    );

    modport slave (
        input  alloc_req, alloc_rs1_tag, alloc_rs2_tag, alloc_rs1_rdy, alloc_rs2_rdy,
        input  wb_valid, wb_tag, schedule_en, flush,
        output alloc_gnt, alloc_addr, iss0_valid, iss1_valid, iss0_addr, iss1_addr,
        output count, full
    );
endinterface

// File: rtl/res_st_sched.sv
// Reservation-station occupancy tracker, tag wakeup and two-wide
// lowest-index-first issue selector.
module res_st_sched #(
    parameter int unsigned RES_ST_DEPTH      = 16,
    parameter int unsigned PHY_RF_ADDR_WIDTH = 6,
    parameter int unsigned TAG_WIDTH         = PHY_RF_ADDR_WIDTH
) (
    input logic           clk,
    input logic           rst,
    res_st_sched_if.slave bus
);
    localparam int unsigned ADDR_W = $clog2(RES_ST_DEPTH);
    localparam int unsigned CNT_W  = ADDR_W + 1;

    logic [RES_ST_DEPTH-1:0] valid;
    logic [RES_ST_DEPTH-1:0] rs1_rdy;
    logic [RES_ST_DEPTH-1:0] rs2_rdy;
    logic [TAG_WIDTH-1:0]    rs1_tag [RES_ST_DEPTH];
    logic [TAG_WIDTH-1:0]    rs2_tag [RES_ST_DEPTH];

    logic                    iss0_valid_q;
    logic                    iss1_valid_q;
    logic [ADDR_W-1:0]       iss0_addr_q;
    logic [ADDR_W-1:0]       iss1_addr_q;
    logic [CNT_W-1:0]        count_q;

    logic [ADDR_W-1:0]       free_addr;
    logic                    free_found;
    logic                    full_c;
    logic                    gnt_c;
    logic                    alloc_rs1_rdy_c;
    logic                    alloc_rs2_rdy_c;
    logic [RES_ST_DEPTH-1:0] eligible;
    logic [RES_ST_DEPTH-1:0] wake_rs1;
    logic [RES_ST_DEPTH-1:0] wake_rs2;
    logic [ADDR_W-1:0]       sel0;
    logic [ADDR_W-1:0]       sel1;
    logic [1:0]              n_found;
    logic                    take0;
    logic                    take1;

    // Lowest-index free entry; stays 0 when the station is full.
    always_comb begin
        free_addr  = '0;
        free_found = 1'b0;
        for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
            if (!valid[i] && !free_found) begin
                free_addr  = ADDR_W'(i);
                free_found = 1'b1;
            end
        end
    end

    assign full_c = (count_q == CNT_W'(RES_ST_DEPTH));
    assign gnt_c  = bus.alloc_req & ~full_c & ~bus.flush & rst;

    // Writeback bypass so an allocating uop never misses a same-cycle broadcast.
    assign alloc_rs1_rdy_c = bus.alloc_rs1_rdy | (bus.wb_valid & (bus.alloc_rs1_tag == bus.wb_tag));
    assign alloc_rs2_rdy_c = bus.alloc_rs2_rdy | (bus.wb_valid & (bus.alloc_rs2_tag == bus.wb_tag));

    always_comb begin
        for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
            wake_rs1[i] = valid[i] & bus.wb_valid & (rs1_tag[i] == bus.wb_tag);
            wake_rs2[i] = valid[i] & bus.wb_valid & (rs2_tag[i] == bus.wb_tag);
        end
    end

    assign eligible = valid & rs1_rdy & rs2_rdy;

    // First and second lowest-index eligible entries from registered state.
    always_comb begin
        sel0    = '0;
        sel1    = '0;
        n_found = 2'd0;
        for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
            if (eligible[i]) begin
                if (n_found == 2'd0) begin
                    sel0 = ADDR_W'(i);
                end else if (n_found == 2'd1) begin
                    sel1 = ADDR_W'(i);
                end
                if (n_found != 2'd2) begin
                    n_found = n_found + 2'd1;
                end
            end
        end
    end

    assign take0 = bus.schedule_en & (n_found != 2'd0);
    assign take1 = bus.schedule_en & (n_found == 2'd2);

    always_ff @(posedge clk) begin
        if (!rst) begin
            valid        <= '0;
            rs1_rdy      <= '0;
            rs2_rdy      <= '0;
            for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
                rs1_tag[i] <= '0;
                rs2_tag[i] <= '0;
            end
            iss0_valid_q <= 1'b0;
            iss1_valid_q <= 1'b0;
            iss0_addr_q  <= '0;
            iss1_addr_q  <= '0;
            count_q      <= '0;
        end else if (bus.flush) begin
            valid        <= '0;
            iss0_valid_q <= 1'b0;
            iss1_valid_q <= 1'b0;
            iss0_addr_q  <= '0;
            iss1_addr_q  <= '0;
            count_q      <= '0;
        end else begin
            for (int i = 0; i < int'(RES_ST_DEPTH); i++) begin
                if (wake_rs1[i]) rs1_rdy[i] <= 1'b1;
                if (wake_rs2[i]) rs2_rdy[i] <= 1'b1;
                if ((take0 && (sel0 == ADDR_W'(i))) || (take1 && (sel1 == ADDR_W'(i)))) begin
                    valid[i] <= 1'b0;
                end
                // The allocated slot is free, so it never collides with an issued one.
                if (gnt_c && (free_addr == ADDR_W'(i))) begin
                    valid[i]   <= 1'b1;
                    rs1_tag[i] <= bus.alloc_rs1_tag;
                    rs2_tag[i] <= bus.alloc_rs2_tag;
                    rs1_rdy[i] <= alloc_rs1_rdy_c;
                    rs2_rdy[i] <= alloc_rs2_rdy_c;
                end
            end
            iss0_valid_q <= take0;
            iss1_valid_q <= take1;
            iss0_addr_q  <= take0 ? sel0 : '0;
            iss1_addr_q  <= take1 ? sel1 : '0;
            count_q      <= count_q + CNT_W'(gnt_c) - CNT_W'(take0) - CNT_W'(take1);
        end
    end

    assign bus.alloc_gnt  = gnt_c;
    assign bus.alloc_addr = free_addr;
    assign bus.full       = full_c;
    assign bus.count      = count_q;
    assign bus.iss0_valid = iss0_valid_q;
    assign bus.iss1_valid = iss1_valid_q;
    assign bus.iss0_addr  = iss0_addr_q;
    assign bus.iss1_addr  = iss1_addr_q;
endmodule

// File: tb/tb_res_st_sched.sv
// Directed bench for res_st_sched: fill/stall, wakeup, bypass, gated issue,
// full boundary, flush and mid-flight reset.
module tb_res_st_sched;
    logic clk = 1'b0;
    logic rst;
    int   n_tests = 0;
    int   n_fail  = 0;

    res_st_sched_if #(.RES_ST_DEPTH(16), .TAG_WIDTH(6)) bus ();

    res_st_sched #(.RES_ST_DEPTH(16), .PHY_RF_ADDR_WIDTH(6), .TAG_WIDTH(6)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_alloc(input logic req, input logic [5:0] t1, input logic r1,
                             input logic [5:0] t2, input logic r2);
        bus.alloc_req     = req;
        bus.alloc_rs1_tag = t1;
        bus.alloc_rs1_rdy = r1;
        bus.alloc_rs2_tag = t2;
        bus.alloc_rs2_rdy = r2;
    endtask

    task automatic chk_iss(input string tag, input logic v0, input logic [3:0] a0,
                           input logic v1, input logic [3:0] a1);
        chk({tag, "_iss0_valid"}, 32'(bus.iss0_valid), 32'(v0));
        chk({tag, "_iss0_addr"},  32'(bus.iss0_addr),  32'(a0));
        chk({tag, "_iss1_valid"}, 32'(bus.iss1_valid), 32'(v1));
        chk({tag, "_iss1_addr"},  32'(bus.iss1_addr),  32'(a1));
    endtask

    initial begin
        logic [5:0] t1;
        logic [5:0] t2;
        logic       r1;

        rst = 1'b0;
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        bus.wb_valid    = 1'b0;
        bus.wb_tag      = 6'h00;
        bus.schedule_en = 1'b0;
        bus.flush       = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        #1;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_alloc_addr", 32'(bus.alloc_addr), 32'd0);
        chk_iss("rst", 1'b0, 4'd0, 1'b0, 4'd0);

        // Fill all 16 entries with waiting uops; entries 3 and 7 wait on tag 0x12.
        for (int i = 0; i < 16; i++) begin
            t1 = 6'(32'h20 + i);
            t2 = 6'(32'h30 + i);
            r1 = 1'b0;
            if (i == 3) begin t1 = 6'h12; t2 = 6'h12; end
            if (i == 7) begin t1 = 6'h01; r1 = 1'b1; t2 = 6'h12; end
            set_alloc(1'b1, t1, r1, t2, 1'b0);
            #1;
            chk("fill_gnt", 32'(bus.alloc_gnt), 32'd1);
            chk("fill_addr", 32'(bus.alloc_addr), 32'(i));
            tick();
        end
        chk("fill_count", 32'(bus.count), 32'd16);
        chk("fill_full", 32'(bus.full), 32'd1);
        #1;
        chk("stall_gnt", 32'(bus.alloc_gnt), 32'd0);
        chk("stall_addr", 32'(bus.alloc_addr), 32'd0);
        tick();
        chk("stall_count", 32'(bus.count), 32'd16);

        // Wakeup on 0x12; same-cycle schedule must not see it.
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        bus.wb_valid    = 1'b1;
        bus.wb_tag      = 6'h12;
        bus.schedule_en = 1'b1;
        tick();
        chk_iss("wake_same", 1'b0, 4'd0, 1'b0, 4'd0);
        bus.wb_valid = 1'b0;
        tick();
        chk_iss("dual", 1'b1, 4'd3, 1'b1, 4'd7);
        chk("dual_count", 32'(bus.count), 32'd14);
        chk("dual_full", 32'(bus.full), 32'd0);
        bus.schedule_en = 1'b0;
        tick();
        chk_iss("dual_after", 1'b0, 4'd0, 1'b0, 4'd0);

        // Allocation bypass: rs1 woken by the same-cycle broadcast.
        set_alloc(1'b1, 6'h05, 1'b0, 6'h06, 1'b1);
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'h05;
        #1;
        chk("byp_gnt", 32'(bus.alloc_gnt), 32'd1);
        chk("byp_addr", 32'(bus.alloc_addr), 32'd3);
        tick();
        chk("byp_count", 32'(bus.count), 32'd15);
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        bus.wb_valid    = 1'b0;
        bus.schedule_en = 1'b1;
        tick();
        chk_iss("byp", 1'b1, 4'd3, 1'b0, 4'd0);
        chk("byp_count2", 32'(bus.count), 32'd14);
        bus.schedule_en = 1'b0;

        // Entry 2: rs1 then rs2 woken; issue held off by schedule_en.
        bus.wb_valid = 1'b1;
        bus.wb_tag   = 6'h22;
        tick();
        bus.wb_tag      = 6'h32;
        bus.schedule_en = 1'b1;
        tick();
        chk("half_ready_iss0_valid", 32'(bus.iss0_valid), 32'd0);
        bus.wb_valid    = 1'b0;
        bus.schedule_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("gated_iss0_valid", 32'(bus.iss0_valid), 32'd0);
        end
        bus.schedule_en = 1'b1;
        tick();
        chk_iss("single", 1'b1, 4'd2, 1'b0, 4'd0);
        chk("single_count", 32'(bus.count), 32'd13);
        bus.schedule_en = 1'b0;

        // Refill to full with ready entries at 2 and 3.
        set_alloc(1'b1, 6'h0a, 1'b1, 6'h0b, 1'b1);
        #1;
        chk("refill_addr2", 32'(bus.alloc_addr), 32'd2);
        tick();
        #1;
        chk("refill_addr3", 32'(bus.alloc_addr), 32'd3);
        tick();
        set_alloc(1'b1, 6'h10, 1'b0, 6'h11, 1'b0);
        #1;
        chk("refill_addr7", 32'(bus.alloc_addr), 32'd7);
        tick();
        chk("refill_full", 32'(bus.full), 32'd1);
        bus.schedule_en = 1'b1;
        #1;
        chk("full_iss_gnt", 32'(bus.alloc_gnt), 32'd0);
        tick();
        chk_iss("full_iss", 1'b1, 4'd2, 1'b1, 4'd3);
        chk("full_iss_count", 32'(bus.count), 32'd14);
        bus.schedule_en = 1'b0;
        #1;
        chk("freed_gnt", 32'(bus.alloc_gnt), 32'd1);
        chk("freed_addr", 32'(bus.alloc_addr), 32'd2);
        tick();
        chk("freed_count", 32'(bus.count), 32'd15);

        // Flush alongside alloc and schedule.
        set_alloc(1'b1, 6'h0a, 1'b1, 6'h0b, 1'b1);
        tick();
        chk("pre_flush_count", 32'(bus.count), 32'd16);
        bus.flush       = 1'b1;
        bus.schedule_en = 1'b1;
        #1;
        chk("flush_gnt", 32'(bus.alloc_gnt), 32'd0);
        tick();
        chk_iss("flush", 1'b0, 4'd0, 1'b0, 4'd0);
        chk("flush_count", 32'(bus.count), 32'd0);
        chk("flush_full", 32'(bus.full), 32'd0);
        bus.flush = 1'b0;
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        #1;
        chk("flush_alloc_addr", 32'(bus.alloc_addr), 32'd0);
        tick();
        chk("post_flush_iss0_valid", 32'(bus.iss0_valid), 32'd0);

        // Reset while issue outputs are in flight.
        bus.schedule_en = 1'b0;
        set_alloc(1'b1, 6'h0a, 1'b1, 6'h0b, 1'b1);
        tick();
        tick();
        tick();
        chk("pre_rst_count", 32'(bus.count), 32'd3);
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        bus.schedule_en = 1'b1;
        tick();
        chk_iss("pre_rst", 1'b1, 4'd0, 1'b1, 4'd1);
        chk("pre_rst_count2", 32'(bus.count), 32'd1);
        rst = 1'b0;
        set_alloc(1'b1, 6'h0a, 1'b1, 6'h0b, 1'b1);
        #1;
        chk("rst_mid_gnt", 32'(bus.alloc_gnt), 32'd0);
        tick();
        chk_iss("rst_mid", 1'b0, 4'd0, 1'b0, 4'd0);
        chk("rst_mid_count", 32'(bus.count), 32'd0);
        chk("rst_mid_alloc_addr", 32'(bus.alloc_addr), 32'd0);
        rst = 1'b1;
        set_alloc(1'b0, 6'h00, 1'b0, 6'h00, 1'b0);
        tick();
        chk("post_rst_iss0_valid", 32'(bus.iss0_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
